battle_hp_datapath: RTL and testbench

Datapath responder to the battle control FSM. It consumes the control strobes apply_damage, active_trainer and target, and turns the attacker's selected move into a damage value. It drains the target's HP one point per cycle, saturating at zero, and returns p_hp and ai_hp, plus faint flags, to the controller and display. Each accepted request is acknowledged with a one-cycle done pulse.

---
 rtl/battle_hp_datapath.sv | 142 ++++++++++++++
 tb/tb_battle_hp_datapath.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/battle_hp_datapath.sv
// HP datapath for the battle controller: turns the attacker's move into damage,
// drains the defender's HP one point per cycle, and acknowledges each request.
module battle_hp_datapath #(
    parameter int HP_W   = 4,
    parameter int MAX_HP = 15,
    parameter int PWR0   = 1,
    parameter int PWR1   = 2,
    parameter int PWR2   = 3,
    parameter int PWR3   = 4
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            new_battle,
    input  logic            apply_damage,
    input  logic            active_trainer,
    input  logic            target,
    input  logic [1:0]      p_move,
    input  logic [1:0]      ai_move,
    output logic [HP_W-1:0] p_hp,
    output logic [HP_W-1:0] ai_hp,
    output logic            p_fainted,
    output logic            ai_fainted,
    output logic            busy,
    output logic            done,
    output logic            err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [HP_W-1:0] MAX_HP_V = HP_W'(MAX_HP);
    localparam logic [HP_W-1:0] PWR0_V   = HP_W'(PWR0);
    localparam logic [HP_W-1:0] PWR1_V   = HP_W'(PWR1);
    localparam logic [HP_W-1:0] PWR2_V   = HP_W'(PWR2);
    localparam logic [HP_W-1:0] PWR3_V   = HP_W'(PWR3);

    state_t          state_q, state_d;
    logic            apply_q, apply_d;
    logic            atk_q, atk_d;
    logic            tgt_q, tgt_d;
    logic            err_pend_q, err_pend_d;
    logic [HP_W-1:0] rem_q, rem_d;
    logic [HP_W-1:0] p_hp_q, p_hp_d;
    logic [HP_W-1:0] ai_hp_q, ai_hp_d;

    logic            req;
    logic [1:0]      move_sel;
    logic [HP_W-1:0] tgt_hp;

    // new_battle is folded into the synchronous reset so both abort identically
    always_ff @(posedge clk) begin
        if (!reset_n || new_battle) begin
            state_q    <= IDLE;
            apply_q    <= 1'b0;
            atk_q      <= 1'b0;
            tgt_q      <= 1'b0;
            err_pend_q <= 1'b0;
            rem_q      <= '0;
            p_hp_q     <= MAX_HP_V;
            ai_hp_q    <= MAX_HP_V;
        end else begin
            state_q    <= state_d;
            apply_q    <= apply_d;
            atk_q      <= atk_d;
            tgt_q      <= tgt_d;
            err_pend_q <= err_pend_d;
            rem_q      <= rem_d;
            p_hp_q     <= p_hp_d;
            ai_hp_q    <= ai_hp_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        apply_d    = apply_damage;
        atk_d      = atk_q;
        tgt_d      = tgt_q;
        err_pend_d = err_pend_q;
        rem_d      = rem_q;
        p_hp_d     = p_hp_q;
        ai_hp_d    = ai_hp_q;

        req      = apply_damage & ~apply_q;
        move_sel = atk_q ? ai_move : p_move;
        tgt_hp   = tgt_q ? ai_hp_q : p_hp_q;

        unique case (state_q)
            IDLE: begin
                if (req) begin
                    atk_d      = active_trainer;
                    tgt_d      = target;
                    err_pend_d = 1'b0;
                    state_d    = CALC;
                end
            end
            CALC: begin
                // Move codes are read here so the controller can settle them after the strobe
                if (atk_q == tgt_q) begin
                    rem_d      = '0;
                    err_pend_d = 1'b1;
                end else begin
                    unique case (move_sel)
                        2'd0:    rem_d = PWR0_V;
                        2'd1:    rem_d = PWR1_V;
                        2'd2:    rem_d = PWR2_V;
                        default: rem_d = PWR3_V;
                    endcase
                end
                state_d = DRAIN;
            end
            DRAIN: begin
                if ((rem_q != '0) && (tgt_hp != '0)) begin
                    rem_d = rem_q - 1'b1;
                    if (tgt_q) begin
                        ai_hp_d = ai_hp_q - 1'b1;
                    end else begin
                        p_hp_d = p_hp_q - 1'b1;
                    end
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                err_pend_d = 1'b0;
                state_d    = IDLE;
            end
        endcase
    end

    assign p_hp       = p_hp_q;
    assign ai_hp      = ai_hp_q;
    assign p_fainted  = (p_hp_q == '0);
    assign ai_fainted = (ai_hp_q == '0);
    assign busy       = (state_q != IDLE);
    assign done       = (state_q == DONE);
    assign err        = (state_q == DONE) && err_pend_q;

endmodule

// File: tb/tb_battle_hp_datapath.sv
// Scoreboard bench for battle_hp_datapath: requests push expected completions,
// a negedge monitor pops and checks them whenever done is seen.
module tb_battle_hp_datapath;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       new_battle;
    logic       apply_damage;
    logic       active_trainer;
    logic       target;
    logic [1:0] p_move;
    logic [1:0] ai_move;
    logic [3:0] p_hp;
    logic [3:0] ai_hp;
    logic       p_fainted;
    logic       ai_fainted;
    logic       busy;
    logic       done;
    logic       err;

    typedef struct {
        int p_hp;
        int ai_hp;
        int err;
        int done_cyc;
    } exp_t;

    exp_t sb_q[$];
    int   cyc    = 0;
    int   errors = 0;
    int   checks = 0;

    battle_hp_datapath dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .new_battle    (new_battle),
        .apply_damage  (apply_damage),
        .active_trainer(active_trainer),
        .target        (target),
        .p_move        (p_move),
        .ai_move       (ai_move),
        .p_hp          (p_hp),
        .ai_hp         (ai_hp),
        .p_fainted     (p_fainted),
        .ai_fainted    (ai_fainted),
        .busy          (busy),
        .done          (done),
        .err           (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        exp_t e;
        if (done) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_done: got done=1, expected no pending request (cycle %0d)", cyc);
            end else begin
                e = sb_q.pop_front();
                checkOutput("done_cycle", cyc, e.done_cyc);
                checkOutput("p_hp_at_done", int'(p_hp), e.p_hp);
                checkOutput("ai_hp_at_done", int'(ai_hp), e.ai_hp);
                checkOutput("err_at_done", int'(err), e.err);
            end
        end else if (err) begin
            checks++;
            errors++;
            $display("[TB] FAIL err_without_done: got err=1, expected 0 (cycle %0d)", cyc);
        end
    end

    // Raises apply_damage for the cycle that follows; caller decides when to drop it
    task automatic applyStimulus(input logic atk, input logic tgt, input logic [1:0] pm,
                                 input logic [1:0] am, input int exp_p, input int exp_ai,
                                 input int exp_err, input int k, input bit expect_done);
        exp_t e;
        @(posedge clk); #1;
        active_trainer = atk;
        target         = tgt;
        p_move         = pm;
        ai_move        = am;
        apply_damage   = 1'b1;
        if (expect_done) begin
            e.p_hp     = exp_p;
            e.ai_hp    = exp_ai;
            e.err      = exp_err;
            e.done_cyc = cyc + 3 + k;
            sb_q.push_back(e);
        end
    endtask

    task automatic release_apply();
        @(posedge clk); #1;
        apply_damage = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((sb_q.size() != 0 || busy) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            checks++;
            errors++;
            $display("[TB] FAIL wait_idle_timeout: got busy=%0d pending=%0d, expected idle", busy, sb_q.size());
            sb_q.delete();
        end
        @(negedge clk);
    endtask

    task automatic pulse_new_battle();
        @(posedge clk); #1;
        new_battle = 1'b1;
        @(posedge clk); #1;
        new_battle = 1'b0;
        checkOutput("reload_p_hp", int'(p_hp), 15);
        checkOutput("reload_ai_hp", int'(ai_hp), 15);
        checkOutput("reload_ai_fainted", int'(ai_fainted), 0);
    endtask

    initial begin
        reset_n        = 1'b0;
        new_battle     = 1'b0;
        apply_damage   = 1'b0;
        active_trainer = 1'b0;
        target         = 1'b0;
        p_move         = 2'd0;
        ai_move        = 2'd0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;

        checkOutput("reset_p_hp", int'(p_hp), 15);
        checkOutput("reset_ai_hp", int'(ai_hp), 15);
        checkOutput("reset_busy", int'(busy), 0);
        checkOutput("reset_done", int'(done), 0);
        checkOutput("reset_p_fainted", int'(p_fainted), 0);
        checkOutput("reset_ai_fainted", int'(ai_fainted), 0);

        // Player move 3 on the AI: watch the drain cycle by cycle
        applyStimulus(1'b0, 1'b1, 2'd3, 2'd0, 15, 11, 0, 4, 1'b1);
        for (int c = 1; c <= 6; c++) begin
            @(posedge clk); #1;
            if (c == 1) apply_damage = 1'b0;
            if (c >= 2) checkOutput("drain_ai_hp", int'(ai_hp), 15 - (c - 2));
            checkOutput("drain_p_hp", int'(p_hp), 15);
            checkOutput("drain_no_done", int'(done), 0);
        end
        wait_idle();

        // Wear the AI down to 2 HP
        applyStimulus(1'b0, 1'b1, 2'd3, 2'd0, 15, 7, 0, 4, 1'b1);
        release_apply();
        wait_idle();
        applyStimulus(1'b0, 1'b1, 2'd3, 2'd0, 15, 3, 0, 4, 1'b1);
        release_apply();
        wait_idle();
        applyStimulus(1'b0, 1'b1, 2'd0, 2'd0, 15, 2, 0, 1, 1'b1);
        release_apply();
        wait_idle();

        // AI move 3 on the player, then player move 2 saturates the AI at 0
        applyStimulus(1'b1, 1'b0, 2'd0, 2'd3, 11, 2, 0, 4, 1'b1);
        release_apply();
        wait_idle();
        applyStimulus(1'b0, 1'b1, 2'd2, 2'd0, 11, 0, 0, 2, 1'b1);
        release_apply();
        wait_idle();
        checkOutput("ai_fainted", int'(ai_fainted), 1);
        checkOutput("p_fainted", int'(p_fainted), 0);

        // A level held for 20 cycles is a single request
        applyStimulus(1'b1, 1'b0, 2'd0, 2'd1, 9, 0, 0, 2, 1'b1);
        repeat (19) begin
            @(posedge clk); #1;
        end
        apply_damage = 1'b0;
        wait_idle();
        checkOutput("held_p_hp", int'(p_hp), 9);

        // A second edge while busy is dropped
        applyStimulus(1'b1, 1'b0, 2'd0, 2'd3, 5, 0, 0, 4, 1'b1);
        release_apply();
        @(posedge clk); #1;
        checkOutput("busy_during_req", int'(busy), 1);
        apply_damage = 1'b1;
        release_apply();
        wait_idle();
        repeat (8) @(negedge clk);
        checkOutput("busy_drop_p_hp", int'(p_hp), 5);

        // Self-target: no damage, err with done at T+3
        applyStimulus(1'b1, 1'b1, 2'd0, 2'd3, 5, 0, 1, 0, 1'b1);
        release_apply();
        wait_idle();

        // Target already at 0: zero damage, no err
        applyStimulus(1'b0, 1'b1, 2'd3, 2'd0, 5, 0, 0, 0, 1'b1);
        release_apply();
        wait_idle();

        // new_battle mid-drain aborts without a done pulse
        pulse_new_battle();
        applyStimulus(1'b0, 1'b1, 2'd3, 2'd0, 0, 0, 0, 0, 1'b0);
        release_apply();
        repeat (3) begin
            @(posedge clk); #1;
        end
        checkOutput("pre_abort_ai_hp", int'(ai_hp), 13);
        new_battle = 1'b1;
        @(posedge clk); #1;
        new_battle = 1'b0;
        checkOutput("abort_p_hp", int'(p_hp), 15);
        checkOutput("abort_ai_hp", int'(ai_hp), 15);
        checkOutput("abort_busy", int'(busy), 0);
        checkOutput("abort_done", int'(done), 0);
        repeat (10) @(negedge clk);
        checkOutput("post_abort_ai_hp", int'(ai_hp), 15);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
